// File: rtl/alu_pkg.sv
// Shared opcodes, instruction layout and FSM state type for the ALU issue front-end.
package alu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 2;
    localparam int OP_W       = 3;
    localparam int INSTR_W    = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_LSL  = 3'd2;
    localparam logic [OP_W-1:0] OP_LSR  = 3'd3;
    localparam logic [OP_W-1:0] OP_AND  = 3'd4;
    localparam logic [OP_W-1:0] OP_OR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_NAND = 3'd7;

    localparam int OP_LSB      = 13;
    localparam int RD_LSB      = 11;
    localparam int RA_LSB      = 9;
    localparam int USE_IMM_BIT = 8;
    localparam int IMM_LSB     = 0;
    localparam int RB_LSB      = 0;

    // Field order matches the bit layout, so a 16-bit word casts straight into this struct.
    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] ra;
        logic                  use_imm;
        logic [DATA_W-1:0]     imm;
    } instr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; pointers carry an extra wrap bit to separate full from empty.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO may still take a push and stay full.
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front-end for the external combinational ALU: FIFO pop, operand fetch,
// result writeback to the 4x8 register file and result reporting.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic [OP_W-1:0]       alu_opcode,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_zero,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int NREGS = 1 << REG_ADDR_W;

    state_t                r_state;
    logic [DATA_W-1:0]     r_rf [0:NREGS-1];
    logic [REG_ADDR_W-1:0] r_rd;
    logic [OP_W-1:0]       r_alu_opcode;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic                  r_out_valid;
    logic [REG_ADDR_W-1:0] r_out_rd;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_out_zero;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [INSTR_W-1:0]    w_head;
    instr_t                w_instr;

    // r0 always reads as zero regardless of what the storage holds.
    function automatic logic [DATA_W-1:0] rf_read(input logic [REG_ADDR_W-1:0] addr);
        return (addr == {REG_ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : r_rf[addr];
    endfunction

    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_instr = instr_t'(w_head);

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_instr),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

    // Issue/writeback FSM together with the register file it updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd         <= {REG_ADDR_W{1'b0}};
            r_alu_opcode <= {OP_W{1'b0}};
            r_alu_a      <= {DATA_W{1'b0}};
            r_alu_b      <= {DATA_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_rd     <= {REG_ADDR_W{1'b0}};
            r_out_data   <= {DATA_W{1'b0}};
            r_out_zero   <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_rf[i] <= {DATA_W{1'b0}};
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state      <= ST_EXEC;
                        r_alu_opcode <= w_instr.op;
                        r_alu_a      <= rf_read(w_instr.ra);
                        r_alu_b      <= w_instr.use_imm ? w_instr.imm
                                                        : rf_read(w_instr.imm[RB_LSB +: REG_ADDR_W]);
                        r_rd         <= w_instr.rd;
                    end
                end
                ST_EXEC: begin
                    if (r_rd != {REG_ADDR_W{1'b0}}) r_rf[r_rd] <= alu_result;
                    r_out_valid <= 1'b1;
                    r_out_rd    <= r_rd;
                    r_out_data  <= alu_result;
                    r_out_zero  <= (alu_result == {DATA_W{1'b0}});
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign busy       = !w_empty || (r_state == ST_EXEC);
    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign out_valid  = r_out_valid;
    assign out_rd     = r_out_rd;
    assign out_data   = r_out_data;
    assign out_zero   = r_out_zero;
    assign dbg_data   = rf_read(dbg_addr);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU closing the loop.
module tb_alu_issue_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        out_valid;
    logic [1:0]  out_rd;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        busy;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_unit #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .busy       (busy),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_LSL:  return {a[6:0], 1'b0};
            OP_LSR:  return {1'b0, a[7:1]};
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    assign alu_result = alu_model(alu_opcode, alu_a, alu_b);

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                       input logic use_imm, input logic [7:0] imm);
        return {op, rd, ra, use_imm, imm};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  rd;
        logic [7:0]  data;
        logic        zero;
        logic [1:0]  dbg_addr;
        logic [7:0]  dbg_exp;
    } vec_t;

    vec_t vecs [12];

    // Push one word from an idle unit and check its single result and timing.
    task automatic run_vec(input vec_t v);
        int lat;
        lat = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        dbg_addr = v.dbg_addr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("vec_latency", 16'(lat), 16'd3);
        chk("vec_rd",      {14'd0, out_rd}, {14'd0, v.rd});
        chk("vec_data",    {8'd0, out_data}, {8'd0, v.data});
        chk("vec_zero",    {15'd0, out_zero}, {15'd0, v.zero});
        chk("vec_dbg",     {8'd0, dbg_data}, {8'd0, v.dbg_exp});
        @(posedge clk); #1;
    endtask

    logic [15:0] bw  [8];
    logic [7:0]  bd  [8];
    logic [1:0]  brd [8];
    logic        exp_rdy [9];

    initial begin
        int sent;
        int got;
        int last_c;
        logic acc;

        vecs[0]  = '{mk(OP_ADD,  2'd1, 2'd0, 1'b1, 8'h05), 2'd1, 8'h05, 1'b0, 2'd1, 8'h05};
        vecs[1]  = '{mk(OP_SUB,  2'd2, 2'd1, 1'b1, 8'h07), 2'd2, 8'hFE, 1'b0, 2'd2, 8'hFE};
        vecs[2]  = '{mk(OP_ADD,  2'd1, 2'd0, 1'b1, 8'h81), 2'd1, 8'h81, 1'b0, 2'd1, 8'h81};
        vecs[3]  = '{mk(OP_LSL,  2'd3, 2'd1, 1'b0, 8'h02), 2'd3, 8'h02, 1'b0, 2'd3, 8'h02};
        vecs[4]  = '{mk(OP_LSR,  2'd3, 2'd3, 1'b0, 8'h00), 2'd3, 8'h01, 1'b0, 2'd3, 8'h01};
        vecs[5]  = '{mk(OP_NAND, 2'd2, 2'd1, 1'b0, 8'h01), 2'd2, 8'h7E, 1'b0, 2'd2, 8'h7E};
        vecs[6]  = '{mk(OP_AND,  2'd3, 2'd2, 1'b1, 8'h0F), 2'd3, 8'h0E, 1'b0, 2'd3, 8'h0E};
        vecs[7]  = '{mk(OP_OR,   2'd3, 2'd3, 1'b0, 8'h01), 2'd3, 8'h8F, 1'b0, 2'd3, 8'h8F};
        vecs[8]  = '{mk(OP_XOR,  2'd0, 2'd0, 1'b1, 8'hFF), 2'd0, 8'hFF, 1'b0, 2'd0, 8'h00};
        vecs[9]  = '{mk(OP_ADD,  2'd1, 2'd0, 1'b1, 8'h00), 2'd1, 8'h00, 1'b1, 2'd1, 8'h00};
        vecs[10] = '{mk(OP_SUB,  2'd2, 2'd0, 1'b1, 8'h01), 2'd2, 8'hFF, 1'b0, 2'd2, 8'hFF};
        vecs[11] = '{mk(OP_ADD,  2'd3, 2'd3, 1'b1, 8'h71), 2'd3, 8'h00, 1'b1, 2'd3, 8'h00};

        for (int k = 0; k < 8; k++) begin
            bd[k]  = 8'h10 + 8'(k);
            brd[k] = 2'(1 + (k % 3));
            bw[k]  = mk(OP_ADD, brd[k], 2'd0, 1'b1, bd[k]);
        end
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 2'd1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready",  {15'd0, in_ready}, 16'd1);
        chk("rst_opcode",    {13'd0, alu_opcode}, 16'd0);
        chk("rst_alu_a",     {8'd0, alu_a}, 16'd0);
        chk("rst_alu_b",     {8'd0, alu_b}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_rd",    {14'd0, out_rd}, 16'd0);
        chk("rst_out_data",  {8'd0, out_data}, 16'd0);
        chk("rst_out_zero",  {15'd0, out_zero}, 16'd0);
        chk("rst_busy",      {15'd0, busy}, 16'd0);
        chk("rst_dbg",       {8'd0, dbg_data}, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Burst of 8 with in_valid held high while words remain; the FIFO fills once and a pop frees it.
        sent     = 0;
        got      = 0;
        last_c   = -1;
        in_valid = 1'b1;
        in_instr = bw[0];
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (c < 9) chk("burst_ready", {15'd0, in_ready}, {15'd0, exp_rdy[c]});
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("burst_data", {8'd0, out_data}, {8'd0, bd[got]});
                chk("burst_rd",   {14'd0, out_rd}, {14'd0, brd[got]});
                if (got == 0) chk("burst_first", 16'(c), 16'd3);
                else          chk("burst_gap", 16'(c - last_c), 16'd2);
                last_c = c;
                got++;
            end else if (c >= 1) begin
                chk("burst_busy", {15'd0, busy}, 16'd1);
            end
            @(posedge clk); #1;
            if (acc) sent++;
            in_valid = (sent < 8);
            in_instr = bw[(sent < 8) ? sent : 7];
        end
        chk("burst_count", 16'(got), 16'd8);
        chk("burst_sent",  16'(sent), 16'd8);
        @(negedge clk);
        chk("burst_busy_end",  {15'd0, busy}, 16'd0);
        chk("burst_no_extra",  {15'd0, out_valid}, 16'd0);
        @(posedge clk); #1;

        // Reset during EXEC of ADD r1,#0x33 with two further words queued.
        in_valid = 1'b1;
        in_instr = mk(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h11);
        @(posedge clk); #1;
        in_instr = mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h33);
        @(posedge clk); #1;
        in_instr = mk(OP_OR, 2'd3, 2'd0, 1'b1, 8'h44);
        @(posedge clk); #1;
        in_instr = mk(OP_XOR, 2'd2, 2'd0, 1'b1, 8'h55);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_alu_b", {8'd0, alu_b}, 16'h0033);
        chk("pre_rst_busy",  {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_in_ready",  {15'd0, in_ready}, 16'd1);
        chk("mid_rst_busy",      {15'd0, busy}, 16'd0);
        chk("mid_rst_alu_b",     {8'd0, alu_b}, 16'd0);
        dbg_addr = 2'd1;
        #1;
        chk("mid_rst_r1", {8'd0, dbg_data}, 16'd0);
        dbg_addr = 2'd2;
        #1;
        chk("mid_rst_r2", {8'd0, dbg_data}, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {15'd0, out_valid}, 16'd0);
            chk("post_rst_idle",  {15'd0, busy}, 16'd0);
        end
        dbg_addr = 2'd1;
        #1;
        chk("post_rst_r1", {8'd0, dbg_data}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
